// File: rtl/gf_mul_if.sv
// gf_mul_if: groups the hash-key load, operand/start and result signals of gf_mul.
//   h_data/h_valid         : hash subkey H and its load strobe (master -> slave)
//   memory_ready           : H table built, multiplier idle      (slave -> master)
//   in_data/in_valid       : operand X and its start strobe      (master -> slave)
//   out_mult/done_calc     : product X*H and one-cycle strobe    (slave -> master)
// All 128-bit fields use GCM order: index 0 is the coefficient of x^0.
interface gf_mul_if;
    logic [0:127] h_data;
    logic         h_valid;
    logic         memory_ready;
    logic [0:127] in_data;
    logic         in_valid;
    logic [0:127] out_mult;
    logic         done_calc;

    modport master (
        output h_data, h_valid, in_data, in_valid,
        input  memory_ready, out_mult, done_calc
    );

    modport slave (
        input  h_data, h_valid, in_data, in_valid,
        output memory_ready, out_mult, done_calc
    );
endinterface

// File: rtl/gf_mul.sv
// gf_mul: GF(2^128) multiplier (GCM polynomial x^128+x^7+x^2+x+1), 4 bits per cycle.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : gf_mul_if.slave (h_data/h_valid, memory_ready, in_data/in_valid,
//           out_mult/done_calc)
// Loading H builds a 16-entry table of nibble multiples of H (memory_ready 17 edges
// after the load). A multiply then runs a Horner scan over the 32 nibbles of X,
// most significant nibble first, delivering the product 33 edges after the start.
// Optional macro GF_MUL_ZERO_SKIP_EN: zero X or zero H completes in one edge.
module gf_mul (
    input logic     clock,
    input logic     reset,
    gf_mul_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBuild, StReady, StMult} state_e;

    // Internally bit i of a 128-bit vector is the coefficient of x^i.
    function automatic logic [127:0] to_poly(input logic [0:127] p);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = p[i];
        return r;
    endfunction

    function automatic logic [0:127] from_poly(input logic [127:0] v);
        logic [0:127] r;
        for (int i = 0; i < 128; i++) r[i] = v[i];
        return r;
    endfunction

    // Multiply by x and fold x^128 back as x^7+x^2+x+1.
    function automatic logic [127:0] mulx(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic logic [127:0] mulx4(input logic [127:0] v);
        return mulx(mulx(mulx(mulx(v))));
    endfunction

    // n(x) * H, where n[j] is the coefficient of x^j.
    function automatic logic [127:0] nib_mult(input logic [127:0] h, input logic [3:0] n);
        logic [127:0] r;
        logic [127:0] hx;
        r  = '0;
        hx = h;
        for (int j = 0; j < 4; j++) begin
            if (n[j]) r = r ^ hx;
            hx = mulx(hx);
        end
        return r;
    endfunction

    state_e       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [127:0] h_q, h_d;
    logic [127:0] tbl_q [16];
    logic [127:0] tbl_d [16];
    logic [127:0] x_q, x_d;
    logic [127:0] z_q, z_d;
    logic [0:127] out_q, out_d;
    logic         done_q, done_d;
    logic         ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        tbl_d   = tbl_q;
        x_d     = x_q;
        z_d     = z_q;
        out_d   = out_q;
        done_d  = 1'b0;
        ready_d = ready_q;

        unique case (state_q)
            StIdle, StReady: begin
                // h_valid has priority over in_valid in READY.
                if (bus.h_valid) begin
                    h_d     = to_poly(bus.h_data);
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = StBuild;
                end else if (state_q == StReady && bus.in_valid) begin
                    x_d     = to_poly(bus.in_data);
                    z_d     = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = StMult;
`ifdef GF_MUL_ZERO_SKIP_EN
                    // Jump straight to the result edge with a zero accumulator.
                    if (bus.in_data == '0 || h_q == '0) begin
                        cnt_d = 6'd32;
                    end
`endif
                end
            end
            StBuild: begin
                if (cnt_q == 6'd16) begin
                    ready_d = 1'b1;
                    state_d = StReady;
                end else begin
                    tbl_d[cnt_q[3:0]] = nib_mult(h_q, cnt_q[3:0]);
                    cnt_d             = cnt_q + 6'd1;
                end
            end
            StMult: begin
                if (cnt_q == 6'd32) begin
                    out_d   = from_poly(z_q);
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = StReady;
                end else begin
                    // Horner step: Z = Z*x^4 + T[top nibble of remaining X].
                    z_d   = mulx4(z_q) ^ tbl_q[x_q[127:124]];
                    x_d   = {x_q[123:0], 4'h0};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            h_q     <= '0;
            for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
            x_q     <= '0;
            z_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            for (int i = 0; i < 16; i++) tbl_q[i] <= tbl_d[i];
            x_q     <= x_d;
            z_q     <= z_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.out_mult     = out_q;
    assign bus.done_calc    = done_q;
    assign bus.memory_ready = ready_q;

endmodule

// File: tb/tb_gf_mul.sv
// tb_gf_mul: directed vector table plus hand-written sequences for gf_mul.
module tb_gf_mul;

`ifdef GF_MUL_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    typedef struct {
        logic [0:127] h;
        logic [0:127] x;
        logic [0:127] p;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    gf_mul_if bus_if ();
    gf_mul dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [0:127] HOne  = 128'h80000000000000000000000000000000;
    localparam logic [0:127] HX    = 128'h40000000000000000000000000000000;
    localparam logic [0:127] HX2   = 128'h20000000000000000000000000000000;
    localparam logic [0:127] HX127 = 128'h00000000000000000000000000000001;
    localparam logic [0:127] HRed  = 128'he1000000000000000000000000000000;
    localparam logic [0:127] H1px  = 128'hc0000000000000000000000000000000;
    localparam logic [0:127] H1px2 = 128'ha0000000000000000000000000000000;

    task automatic check_val(input string name, input logic [0:127] act, input logic [0:127] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_h(input logic [0:127] h, input string name);
        int lat;
        @(negedge clock);
        bus_if.h_data  = h;
        bus_if.h_valid = 1'b1;
        @(posedge clock);
        #1;
        bus_if.h_valid = 1'b0;
        check_int({name, " ready low after load"}, int'(bus_if.memory_ready), 0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
            if (bus_if.memory_ready) break;
        end
        check_int({name, " build latency"}, lat, 17);
    endtask

    task automatic run_mult(input logic [0:127] x, input logic [0:127] exp, input int exp_lat,
                            input string name);
        int lat;
        @(negedge clock);
        bus_if.in_data  = x;
        bus_if.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clock);
            lat++;
            #1;
            if (bus_if.done_calc) break;
        end
        check_int({name, " mult latency"}, lat, exp_lat);
        check_val({name, " product"}, bus_if.out_mult, exp);
        @(posedge clock);
        #1;
        check_int({name, " done one cycle"}, int'(bus_if.done_calc), 0);
        check_int({name, " ready after done"}, int'(bus_if.memory_ready), 1);
        check_val({name, " product held"}, bus_if.out_mult, exp);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int dones;
        int ready_seen;
        int exp_lat;

        vecs[0] = '{HOne, 128'h42831ec2217774244b7221b784d0d49c,
                    128'h42831ec2217774244b7221b784d0d49c};
        vecs[1] = '{HX, HX, HX2};
        vecs[2] = '{HX, HX127, HRed};
        vecs[3] = '{HX127, HX, HRed};
        vecs[4] = '{HOne, HOne, HOne};
        vecs[5] = '{HX127, HX127, 128'he6080000000000000000000000000003};
        vecs[6] = '{H1px, H1px, H1px2};
        vecs[7] = '{128'h08000000000000000000000000000000,
                    128'h10000000000000000000000000000000,
                    128'h01000000000000000000000000000000};
        vecs[8] = '{128'h00000000000000008000000000000000,
                    128'h00000000000000008000000000000000, HRed};
        vecs[9] = '{128'h0123456789abcdef0123456789abcdef, 128'h0, 128'h0};

        reset           = 1'b1;
        bus_if.h_data   = '0;
        bus_if.h_valid  = 1'b0;
        bus_if.in_data  = '0;
        bus_if.in_valid = 1'b0;
        #12;
        check_int("reset ready", int'(bus_if.memory_ready), 0);
        check_int("reset done", int'(bus_if.done_calc), 0);
        check_val("reset out", bus_if.out_mult, 128'h0);
        @(negedge clock);
        reset = 1'b0;

        // In IDLE, in_valid alone is ignored.
        @(negedge clock);
        bus_if.in_data  = HX;
        bus_if.in_valid = 1'b1;
        @(negedge clock);
        bus_if.in_valid = 1'b0;
        dones = 0;
        ready_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus_if.done_calc) dones++;
            if (bus_if.memory_ready) ready_seen++;
        end
        check_int("idle in_valid dones", dones, 0);
        check_int("idle ready stays low", ready_seen, 0);

        for (int i = 0; i < 10; i++) begin
            exp_lat = (ZeroSkip && (vecs[i].x == '0 || vecs[i].h == '0)) ? 1 : 33;
            load_h(vecs[i].h, $sformatf("vec%0d", i));
            run_mult(vecs[i].x, vecs[i].p, exp_lat, $sformatf("vec%0d", i));
        end

        // h_valid (and in_valid) during BUILD ignored; first H retained.
        @(negedge clock);
        bus_if.h_data  = HX;
        bus_if.h_valid = 1'b1;
        @(posedge clock);
        #1;
        bus_if.h_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clock);
            if (lat == 5) begin
                bus_if.h_data   = H1px;
                bus_if.h_valid  = 1'b1;
                bus_if.in_data  = HOne;
                bus_if.in_valid = 1'b1;
            end else begin
                bus_if.h_valid  = 1'b0;
                bus_if.in_valid = 1'b0;
            end
            @(posedge clock);
            lat++;
            #1;
            if (bus_if.memory_ready) break;
        end
        bus_if.h_valid  = 1'b0;
        bus_if.in_valid = 1'b0;
        check_int("build ignore latency", lat, 17);
        run_mult(HX, HX2, 33, "after build inject");

        // in_valid and h_valid during MULT ignored; exactly one done.
        @(negedge clock);
        bus_if.in_data  = HX;
        bus_if.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        dones = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clock);
            if (c == 10) begin
                bus_if.in_data  = HOne;
                bus_if.in_valid = 1'b1;
                bus_if.h_data   = H1px;
                bus_if.h_valid  = 1'b1;
            end else begin
                bus_if.in_valid = 1'b0;
                bus_if.h_valid  = 1'b0;
            end
            @(posedge clock);
            #1;
            if (bus_if.done_calc) begin
                dones++;
                check_int("mult inject done edge", c, 33);
                check_val("mult inject product", bus_if.out_mult, HX2);
            end
        end
        check_int("mult inject done count", dones, 1);
        run_mult(HOne, HX, 33, "H retained");

        // Simultaneous h_valid and in_valid in READY: h_valid wins.
        @(negedge clock);
        bus_if.h_data   = H1px;
        bus_if.h_valid  = 1'b1;
        bus_if.in_data  = HX;
        bus_if.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus_if.h_valid  = 1'b0;
        bus_if.in_valid = 1'b0;
        check_int("both valid ready low", int'(bus_if.memory_ready), 0);
        lat = 0;
        dones = 0;
        while (lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
            if (bus_if.done_calc) dones++;
            if (bus_if.memory_ready) break;
        end
        check_int("both valid build latency", lat, 17);
        check_int("both valid no done", dones, 0);
        run_mult(H1px, H1px2, 33, "new H after both");

        // Reset at MULT cycle 10.
        @(negedge clock);
        bus_if.in_data  = HX;
        bus_if.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_int("mid-mult reset ready", int'(bus_if.memory_ready), 0);
        check_int("mid-mult reset done", int'(bus_if.done_calc), 0);
        check_val("mid-mult reset out", bus_if.out_mult, 128'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        bus_if.in_data  = HX;
        bus_if.in_valid = 1'b1;
        @(negedge clock);
        bus_if.in_valid = 1'b0;
        dones = 0;
        ready_seen = 0;
        repeat (50) begin
            @(posedge clock);
            #1;
            if (bus_if.done_calc) dones++;
            if (bus_if.memory_ready) ready_seen++;
        end
        check_int("post reset dones", dones, 0);
        check_int("post reset ready low", ready_seen, 0);
        load_h(HX, "reload");
        run_mult(HX, HX2, 33, "reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
